uart_receiver: RTL and testbench

Serial-to-parallel UART receiver that sits directly behind the `FPGA_SERIAL_RX` pin of the `Riscv151` core. It turns 8N1 frames from the host into bytes and presents them on a ready/valid interface to the CPU's memory-mapped UART control/data registers. It is the block that accepts every character the host sends (BIOS commands, echoed input).

---
 rtl/uart_defs.sv | 30 +++
 rtl/uart_receiver_synchronizer.sv | 27 ++
 rtl/uart_receiver.sv | 181 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared 8N1 UART definitions: FSM state encoding, frame constants, bit-timing helpers.
// Latency: n/a (compile-time constants and pure functions only).
// Backpressure: n/a.
package uart_defs;

    // 8N1 frame layout: one start bit, eight data bits LSB-first, one stop bit.
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

    // Receiver/transmitter frame-walk states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_t;

    // Core clock cycles per bit period (integer division).
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Offset from the start-bit edge to the middle of the start bit.
    function automatic int sample_time(input int clock_freq, input int baud_rate);
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_receiver_synchronizer.sv
// Two-flop synchronizer for asynchronous inputs, parameterized width and reset value.
// Latency: 2 clk cycles from input change to sync_out.
// Backpressure: none; samples every cycle.
module synchronizer #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= RESET_VALUE;
            sync_out <= RESET_VALUE;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampling-free mid-bit sampler feeding a 1-entry ready/valid holding register.
// Latency: data_out_valid rises 2 + SAMPLE_TIME + 9*SYMBOL_EDGE_TIME + 1 cycles after the pin falls.
// Backpressure: one byte buffered; a byte completing while the buffer is full and not being drained is dropped with an overrun pulse.
module uart_receiver
    import uart_defs::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 overrun,
    output logic                 framing_error
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
    // Keep at least one counter bit so degenerate rates still elaborate.
    localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [IDX_W-1:0] LAST_BIT    = IDX_W'(DATA_BITS - 1);

    logic                 rx;
    uart_state_t          state;
    uart_state_t          state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;

    logic cnt_clr;
    logic idx_clr;
    logic shift_en;
    logic commit;
    logic frame_err;
    logic handshake;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
    synchronizer #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (serial_in),
        .sync_out (rx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame walk: decides sampling points and produces commit/framing strobes.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        idx_clr   = 1'b0;
        shift_en  = 1'b0;
        commit    = 1'b0;
        frame_err = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!rx) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                // Re-check the start bit mid-period; a high line here was a glitch.
                if (cnt == SAMPLE_LAST) begin
                    if (rx) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_clr   = 1'b1;
                        idx_clr   = 1'b1;
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (cnt == SYMBOL_LAST) begin
                    shift_en = 1'b1;
                    cnt_clr  = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Returning to IDLE right at the stop sample leaves half a bit of
                // slack to catch a back-to-back start bit.
                if (cnt == SYMBOL_LAST) begin
                    cnt_clr = 1'b1;
                    if (rx) begin
                        commit    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_nxt = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low line (break) must not re-trigger a frame.
                if (rx) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bit-period counter and data bit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (idx_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // LSB-first shift register: each new bit enters at the top and walks down.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= {rx, shreg[DATA_BITS-1:1]};
        end
    end

    assign handshake = data_out_valid && data_out_ready;

    // Single-entry holding register with overrun/framing strobes aligned to valid rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            overrun        <= 1'b0;
            framing_error  <= 1'b0;
        end else begin
            overrun       <= 1'b0;
            framing_error <= frame_err;
            if (commit) begin
                if (!data_out_valid || handshake) begin
                    // Slot is free, or is being drained this very cycle.
                    data_out       <= shreg;
                    data_out_valid <= 1'b1;
                end else begin
                    // Keep the unconsumed byte; the new one is lost.
                    overrun <= 1'b1;
                end
            end else if (handshake) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven on the pin, expected bytes queued, monitor compares on handshake.
// Latency: checks valid rise at 2 + SAMPLE_TIME + 9*SYMBOL_EDGE_TIME + 1 cycles (+/-1).
// Backpressure: exercises held bytes, overrun, and drain coinciding with a new commit.
module tb_uart_receiver;

    localparam int CLK_F = 50_000_000;
    localparam int BAUD  = 115_200;
    localparam int E     = CLK_F / BAUD;        // 434 cycles per bit
    localparam int S     = E / 2;               // 217
    localparam int LAT   = 2 + S + 9 * E + 1;   // 4126: pin fall to valid rise
    localparam int FULL  = 10 * E;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b1;
    logic       data_out_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       overrun;
    logic       framing_error;

    uart_receiver #(
        .CLOCK_FREQ (CLK_F),
        .BAUD_RATE  (BAUD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .overrun        (overrun),
        .framing_error  (framing_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: what the receiver should hand over, and event totals.
    logic [7:0] exp_q[$];
    int         exp_overruns = 0;
    int         exp_ferrs    = 0;
    bit         model_held   = 1'b0;

    // Monitor observations.
    int valid_cycles   = 0;
    int overrun_pulses = 0;
    int ferr_pulses    = 0;
    int rise_cyc       = -1;
    int last_fall      = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // A frame with a good stop bit yields a byte unless the one-entry slot is
    // still occupied by a byte nobody is draining; a bad stop bit yields an error only.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit drained);
        if (!stop_ok) begin
            exp_ferrs++;
        end else if (drained || !model_held) begin
            exp_q.push_back(b);
            model_held = !drained;
        end else begin
            exp_overruns++;
        end
    endtask

    // Drive a 8N1 frame; stop after 'limit' cycles (FULL for a whole frame).
    task automatic send_frame(input logic [7:0] b, input bit stop_val, input bit rand_ready, input int limit);
        logic [9:0] bits;
        int n;
        bits = {stop_val, b, 1'b0};
        n = 0;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < E; c++) begin
                if (n < limit) begin
                    @(posedge clk);
                    #1;
                    serial_in = bits[i];
                    if (n == 0) last_fall = cyc;
                    if (rand_ready) data_out_ready = 1'($urandom_range(0, 1));
                    n++;
                end
            end
        end
    endtask

    task automatic drive_level(input logic lvl, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            serial_in = lvl;
        end
    endtask

    task automatic ready_pulse();
        @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
        model_held = 1'b0;
    endtask

    // Monitor: counts strobes and pops the scoreboard on each handshake.
    initial begin
        logic [7:0] e;
        logic       prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (data_out_valid) valid_cycles++;
                if (overrun) overrun_pulses++;
                if (framing_error) ferr_pulses++;
                if (data_out_valid && !prev_valid) rise_cyc = cyc;
                if (data_out_valid && data_out_ready) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", data_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", int'(data_out), int'(e));
                    end
                end
            end
            prev_valid = data_out_valid;
        end
    end

    initial begin
        int v0;
        int lat;
        logic [7:0] burst [5];
        logic [7:0] rb;
        bit         rs;
        burst = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h20};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", int'(data_out), 0);
        check("rst_valid", int'(data_out_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_framing", int'(framing_error), 0);
        rst = 1'b0;
        drive_level(1'b1, 20);

        // Single byte, consumer stalled.
        model_frame(8'h61, 1'b1, 1'b0);
        send_frame(8'h61, 1'b1, 1'b0, FULL);
        lat = rise_cyc - last_fall;
        compared++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            mismatched++;
            $display("FAIL latency: got %0d cycles, expected %0d +/- 1", lat, LAT);
        end
        drive_level(1'b1, 50);
        check("single_valid_held", int'(data_out_valid), 1);
        check("single_data", int'(data_out), 'h61);
        ready_pulse();
        check("single_valid_after_hs", int'(data_out_valid), 0);

        // Back-to-back burst with the consumer always ready.
        data_out_ready = 1'b1;
        v0 = valid_cycles;
        foreach (burst[i]) begin
            model_frame(burst[i], 1'b1, 1'b1);
            send_frame(burst[i], 1'b1, 1'b0, FULL);
        end
        drive_level(1'b1, E);
        data_out_ready = 1'b0;
        check("burst_valid_cycles", valid_cycles - v0, 5);
        check("burst_overruns", overrun_pulses, exp_overruns);
        check("burst_drained", exp_q.size(), 0);

        // Overrun: second byte arrives while the first is still held.
        model_frame(8'h73, 1'b1, 1'b0);
        model_frame(8'h77, 1'b1, 1'b0);
        send_frame(8'h73, 1'b1, 1'b0, FULL);
        send_frame(8'h77, 1'b1, 1'b0, FULL);
        drive_level(1'b1, 100);
        check("overrun_pulses", overrun_pulses, exp_overruns);
        check("overrun_data_kept", int'(data_out), 'h73);
        ready_pulse();
        check("overrun_valid_after_hs", int'(data_out_valid), 0);

        // Short glitch on an idle line.
        v0 = valid_cycles;
        drive_level(1'b0, 100);
        drive_level(1'b1, 800);
        check("glitch_valid_cycles", valid_cycles - v0, 0);
        check("glitch_framing", ferr_pulses, exp_ferrs);

        // Bad stop bit followed by a held-low line (break).
        v0 = valid_cycles;
        model_frame(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, FULL);
        drive_level(1'b0, 3 * E);
        drive_level(1'b1, 2 * E);
        check("framing_pulses", ferr_pulses, exp_ferrs);
        check("framing_valid_cycles", valid_cycles - v0, 0);

        // Reset in the middle of data bit 4; the sender abandons the frame.
        send_frame(8'hca, 1'b1, 1'b0, 5 * E + E / 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        serial_in = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_data_out", int'(data_out), 0);
        check("midrst_valid", int'(data_out_valid), 0);
        check("midrst_overrun", int'(overrun), 0);
        check("midrst_framing", int'(framing_error), 0);
        v0 = valid_cycles;
        drive_level(1'b1, 2 * E);
        check("midrst_no_valid", valid_cycles - v0, 0);
        model_frame(8'h0d, 1'b1, 1'b0);
        send_frame(8'h0d, 1'b1, 1'b0, FULL);
        check("after_rst_valid", int'(data_out_valid), 1);
        check("after_rst_data", int'(data_out), 'h0d);

        // Drain of 0x0d lands exactly in the commit cycle of 0x0a.
        model_held = 1'b0;
        model_frame(8'h0a, 1'b1, 1'b0);
        fork
            send_frame(8'h0a, 1'b1, 1'b0, FULL);
            begin
                @(posedge clk);
                repeat (LAT - 1) @(posedge clk);
                #1;
                data_out_ready = 1'b1;
                @(posedge clk);
                #1;
                data_out_ready = 1'b0;
            end
        join
        check("coinc_valid", int'(data_out_valid), 1);
        check("coinc_data", int'(data_out), 'h0a);
        check("coinc_overruns", overrun_pulses, exp_overruns);
        ready_pulse();
        check("coinc_valid_after_hs", int'(data_out_valid), 0);

        // Random bytes, random stop-bit quality, consumer ready toggling randomly.
        for (int k = 0; k < 3; k++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            model_frame(rb, rs, 1'b1);
            send_frame(rb, rs, 1'b1, FULL);
            drive_level(1'b1, rs ? 10 : E);
        end
        data_out_ready = 1'b1;
        drive_level(1'b1, E);
        data_out_ready = 1'b0;
        check("rand_drained", exp_q.size(), 0);
        check("rand_overruns", overrun_pulses, exp_overruns);
        check("rand_framing", ferr_pulses, exp_ferrs);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
